uart_rx_fifo: RTL

Parametrised UART receiver that supersedes the single-byte, start-pulsed receiver. It free-runs on the `rxd` line with no per-byte `start` request. Each bit is majority-voted at mid-bit, with configurable data width, parity and stop bits. Received frames, tagged with parity/framing errors, go into a show-ahead FIFO drained over a valid/ready handshake by the downstream command/program loader.

---
 rtl/uart_rx_fifo_if.sv | 36 +++
 rtl/uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Receive-side valid/ready handshake between the UART receiver
//               FIFO and its downstream consumer. Carries the head frame's
//               data and error tags.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx_valid;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    // Receiver side: presents the FIFO head, accepts pops
    modport master (
        output rx_valid,
        output rx_data,
        output rx_parity_err,
        output rx_frame_err,
        input  rx_ready
    );

    // Consumer side: observes the head, requests pops
    modport slave (
        input  rx_valid,
        input  rx_data,
        input  rx_parity_err,
        input  rx_frame_err,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Free-running UART receiver with 3-sample mid-bit majority
//               vote, configurable data/parity/stop format, and a show-ahead
//               frame FIFO tagged with parity and framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int BAUD       = 115200,
    parameter int CLOCK_FREQ = 25_500_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              rxd,
    input  wire logic                              overrun_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        rx_count,
    output logic                                   overrun,
    output logic                                   busy,
    uart_rx_fifo_if.master                         rx_if
);

    localparam int c_BIT_PERIOD = CLOCK_FREQ / BAUD;
    localparam int c_H          = c_BIT_PERIOD / 2;
    localparam int c_CW         = $clog2(c_BIT_PERIOD);
    localparam int c_IW         = $clog2(DATA_BITS);
    localparam int c_AW         = $clog2(FIFO_DEPTH);
    localparam int c_NW         = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_rxs;
    logic [2:0]           r_state;
    logic                 r_armed;
    logic [c_CW-1:0]      r_cnt;
    logic [c_IW-1:0]      r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_v0;
    logic                 r_v1;

    logic                 w_dec;
    logic                 w_end;
    logic                 w_vote;
    logic                 w_xor;
    logic                 w_perr;
    logic                 w_last_stop;
    logic                 w_push;
    logic                 w_push_ferr;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem_data [FIFO_DEPTH];
    logic                 r_mem_perr [FIFO_DEPTH];
    logic                 r_mem_ferr [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wptr;
    logic [c_AW-1:0]      r_rptr;
    logic [c_NW-1:0]      r_count;
    logic                 r_overrun;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_drop;

    // Two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    // Slot timing, majority vote and parity evaluation
    always_comb begin
        w_dec       = (r_cnt == c_CW'(c_H + 1));
        w_end       = (r_cnt == c_CW'(c_BIT_PERIOD - 1));
        w_vote      = (r_v0 & r_v1) | (r_v0 & r_rxs) | (r_v1 & r_rxs);
        w_xor       = (^r_shreg) ^ w_vote;
        w_perr      = (PARITY == 1) ? ~w_xor : w_xor;
        w_last_stop = (STOP_BITS == 1) || r_stop_idx;
        w_push      = (r_state == S_STOP) && w_dec && w_last_stop;
        w_push_ferr = r_ferr | ~w_vote;
    end

    // Frame FSM: start detection, bit sampling, error tagging
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shreg    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
        end else begin
            if (r_cnt == c_CW'(c_H - 1)) r_v0 <= r_rxs;
            if (r_cnt == c_CW'(c_H))     r_v1 <= r_rxs;
            r_cnt <= w_end ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_armed) begin
                        r_armed <= r_rxs;
                    end else if (!r_rxs) begin
                        // The detecting cycle is count 0, so the slot resumes at 1
                        r_state <= S_START;
                        r_armed <= 1'b0;
                        r_cnt   <= c_CW'(1);
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_vote) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first; shifting right lands it in bit 0
                    if (w_dec) r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
                    if (w_end) begin
                        if (r_bit_idx == c_IW'(DATA_BITS - 1)) begin
                            r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_dec) r_perr <= w_perr;
                    if (w_end) begin
                        r_state    <= S_STOP;
                        r_stop_idx <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_dec && !w_vote) r_ferr <= 1'b1;
                    // Leaving at the decision point lets the next start edge
                    // be caught in the back half of the stop bit
                    if (w_push) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_end) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // FIFO push/pop qualification
    always_comb begin
        w_full    = (r_count == c_NW'(FIFO_DEPTH));
        w_pop     = (r_count != '0) && rx_if.rx_ready;
        w_push_ok = w_push && (!w_full || w_pop);
        w_drop    = w_push && w_full && !w_pop;
    end

    // Frame storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_perr[i] <= 1'b0;
                r_mem_ferr[i] <= 1'b0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem_data[r_wptr] <= r_shreg;
                r_mem_perr[r_wptr] <= r_perr;
                r_mem_ferr[r_wptr] <= w_push_ferr;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun flag; a new drop outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // Outputs are taken straight from registered state
    always_comb begin
        rx_if.rx_valid      = (r_count != '0);
        rx_if.rx_data       = r_mem_data[r_rptr];
        rx_if.rx_parity_err = r_mem_perr[r_rptr];
        rx_if.rx_frame_err  = r_mem_ferr[r_rptr];
        rx_count            = r_count;
        overrun             = r_overrun;
        busy                = (r_state != S_IDLE);
    end

endmodule
`default_nettype wire
